// File: rtl/sort_sequencer.sv
// Bubble-sort engine driving one shared external comparator: load DEPTH elements,
// sort in place one compare per cycle, stream out ascending. Optional macro EARLY_EXIT_EN.
module sort_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic [W-1:0] cmp_low,
  output logic [W-1:0] cmp_high,
  input  logic         cmp_gte
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_CMP  = IDX_W'(DEPTH - 2);
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(DEPTH - 2);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_SORT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [W-1:0]       mem_q [DEPTH];
  logic [W-1:0]       mem_d [DEPTH];
  logic [IDX_W-1:0]   k_q, k_d;
  logic [IDX_W-1:0]   j_q, j_d;
  logic [IDX_W-1:0]   p_q, p_d;
  logic               swap_q, swap_d;
  logic [IDX_W-1:0]   j_nx;
  logic               pass_exit;

  assign j_nx = j_q + IDX_W'(1);

  // State, array and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_LOAD;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      k_q     <= '0;
      j_q     <= '0;
      p_q     <= '0;
      swap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
      k_q     <= k_d;
      j_q     <= j_d;
      p_q     <= p_d;
      swap_q  <= swap_d;
    end
  end

  // Next-state, array update and counter sequencing
  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    k_d       = k_q;
    j_d       = j_q;
    p_d       = p_q;
    swap_d    = swap_q;
    pass_exit = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          mem_d[k_q] = in_data;
          if (k_q == LAST_IDX) begin
            k_d     = '0;
            j_d     = '0;
            p_d     = '0;
            swap_d  = 1'b0;
            state_d = S_SORT;
          end else begin
            k_d = k_q + IDX_W'(1);
          end
        end
      end
      S_SORT: begin
        // cmp_gte low means mem[j] > mem[j+1]; equal pairs stay put
        if (!cmp_gte) begin
          mem_d[j_q]  = mem_q[j_nx];
          mem_d[j_nx] = mem_q[j_q];
          swap_d      = 1'b1;
        end
        if (j_q == LAST_CMP) begin
          j_d    = '0;
          p_d    = p_q + IDX_W'(1);
          swap_d = 1'b0;
`ifdef EARLY_EXIT_EN
          pass_exit = (p_q == LAST_PASS) || !(swap_q || !cmp_gte);
`else
          pass_exit = (p_q == LAST_PASS);
`endif
          if (pass_exit) begin
            k_d     = '0;
            state_d = S_OUT;
          end
        end else begin
          j_d = j_nx;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (k_q == LAST_IDX) begin
            k_d     = '0;
            state_d = S_LOAD;
          end else begin
            k_d = k_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Output decodes of registered state
  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q == S_SORT);
  assign out_last  = (state_q == S_OUT) && (k_q == LAST_IDX);
  assign out_data  = mem_q[k_q];
  assign cmp_low   = (state_q == S_SORT) ? mem_q[j_q]  : '0;
  assign cmp_high  = (state_q == S_SORT) ? mem_q[j_nx] : '0;

endmodule
